speed_regulator: RTL

- Parametrised closed-loop motor speed regulator. It replaces the fixed 8-bit accelerate/brake speed block.
- Each update tick it compares the registered speed with a target and selects ACCEL, CRUISE or BRAKE with a hysteresis band.
- It applies rate-limited acceleration or braking minus an external load term, with saturating arithmetic.
- It sits between the operator/target logic and the motor drive stage. It drives the drive's accel/brake commands and reports the modelled speed.

---
 rtl/speed_pkg.sv | 27 ++
 rtl/speed_prescaler.sv | 27 ++
 rtl/speed_regulator.sv | 95 +++++++++
 3 files changed

// File: rtl/speed_pkg.sv
// Shared types and helpers for the speed regulator: state encoding and
// the saturating clamp used by the speed datapath.
package speed_pkg;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_ACCEL  = 2'd1;
    localparam logic [1:0] ENC_CRUISE = 2'd2;
    localparam logic [1:0] ENC_BRAKE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ENC_IDLE,
        ACCEL  = ENC_ACCEL,
        CRUISE = ENC_CRUISE,
        BRAKE  = ENC_BRAKE
    } state_t;

    // Clamp a signed sum into [0, max_val]; wide enough for any WIDTH <= 32.
    function automatic logic [33:0] sat_add(input logic signed [33:0] sum,
                                            input logic [33:0]        max_val);
        if (sum < 0)
            return '0;
        if ($unsigned(sum) > max_val)
            return max_val;
        return $unsigned(sum);
    endfunction

endpackage

// File: rtl/speed_prescaler.sv
// Free-running update prescaler: tick is high on the last cycle of each
// TICK_DIV-cycle period (always high when TICK_DIV == 1).
module speed_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/speed_regulator.sv
// Closed-loop speed regulator: hysteretic ACCEL/CRUISE/BRAKE selection with
// rate-limited, saturating speed updates on every prescaler tick.
module speed_regulator
    import speed_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_STEP  = 10,
    parameter int BRK_STEP  = 10,
    parameter int HYST      = 2,
    parameter int MAX_SPEED = 200,
    parameter int TICK_DIV  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] threshold,
    input  logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] speed,
    output logic [WIDTH-1:0] accel_cmd,
    output logic [WIDTH-1:0] brake_cmd,
    output logic [1:0]       state,
    output logic             at_target
);

    localparam int XW = WIDTH + 1;
    localparam logic [XW-1:0] MAX_X  = XW'(MAX_SPEED);
    localparam logic [XW-1:0] HYST_X = XW'(HYST);
    localparam logic [XW-1:0] ACC_X  = XW'(ACC_STEP);
    localparam logic [XW-1:0] BRK_X  = XW'(BRK_STEP);

    logic           tick;
    state_t         st, nst;
    logic [XW-1:0]  speed_x, thr_x, target_x, diff_up, diff_dn, acc_x, brk_x;
    logic [WIDTH-1:0] a, b, speed_nxt;
    logic signed [WIDTH+1:0] sum;

    speed_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // One extra bit keeps speed+HYST and target+HYST from wrapping.
    assign speed_x  = {1'b0, speed};
    assign thr_x    = {1'b0, threshold};
    assign target_x = (thr_x > MAX_X) ? MAX_X : thr_x;
    assign diff_up  = target_x - speed_x;
    assign diff_dn  = speed_x - target_x;

    always_comb begin
        nst   = CRUISE;
        acc_x = '0;
        brk_x = '0;
        if (!en)
            nst = IDLE;
        else if (target_x > speed_x + HYST_X)
            nst = ACCEL;
        else if (speed_x > target_x + HYST_X)
            nst = BRAKE;
        else
            nst = CRUISE;

        // Step is capped by the remaining distance so we never overshoot.
        if (nst == ACCEL)
            acc_x = (diff_up < ACC_X) ? diff_up : ACC_X;
        if (nst == BRAKE)
            brk_x = (diff_dn < BRK_X) ? diff_dn : BRK_X;
    end

    assign a = WIDTH'(acc_x);
    assign b = WIDTH'(brk_x);

    assign sum = $signed({2'b00, speed}) + $signed({2'b00, a})
               - $signed({2'b00, b}) - $signed({2'b00, load});
    assign speed_nxt = WIDTH'(sat_add(34'(sum), 34'(MAX_SPEED)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed     <= '0;
            st        <= IDLE;
            accel_cmd <= '0;
            brake_cmd <= '0;
            at_target <= 1'b0;
        end else if (tick) begin
            speed     <= speed_nxt;
            st        <= nst;
            accel_cmd <= a;
            brake_cmd <= b;
            at_target <= (nst == CRUISE);
        end
    end

    assign state = st;

endmodule
